// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: memory-mapped UART peripheral on the 8227 CPU bus.
// DATA writes feed a TX FIFO that drains to the board UART. Bytes from the
// board UART fill an RX FIFO that the CPU pops by reading DATA.
// Optional feature macro: UART_BRIDGE_IRQ_EN adds the irq output and the CTRL rxIrqEn bit.
`timescale 1ns/1ps

module uart_bus_bridge #(
  parameter logic [7:0]  BASE_HIGH = 8'hE0,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       readNotWrite,
  input  logic [7:0] addressBusHigh,
  input  logic [7:0] addressBusLow,
  input  logic [7:0] writeData,
  output logic [7:0] readData,
  output logic       select,
  output logic [7:0] txdata,
  output logic       txclk,
  input  logic       txready,
  input  logic [7:0] rxdata,
  output logic       rxclk,
  input  logic       rxready
`ifdef UART_BRIDGE_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_WAIT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT} rx_state_t;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [7:0]         tx_mem [DEPTH];
  logic [7:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0]      tx_count, rx_count;
  logic               tx_full, tx_not_empty, rx_full, rx_not_empty;
  logic               tx_push, tx_pop, rx_push, rx_pop;
  logic               tx_ovf_set, rx_ovr_set;
  logic               tx_overflow, rx_overrun;
  logic               bus_rd, bus_wr, status_rd;
  logic [1:0]         reg_sel;
  logic [7:0]         status_val, ctrl_val;

  // Bus decode; the 4-byte window sits at BASE_HIGH:00..03
  assign select    = (addressBusHigh == BASE_HIGH) && (addressBusLow[7:2] == 6'd0);
  assign reg_sel   = addressBusLow[1:0];
  assign bus_rd    = select && readNotWrite;
  assign bus_wr    = select && !readNotWrite;
  assign status_rd = bus_rd && (reg_sel == 2'd1);

  assign tx_full      = (tx_count == FULL_CNT);
  assign tx_not_empty = (tx_count != '0);
  assign rx_full      = (rx_count == FULL_CNT);
  assign rx_not_empty = (rx_count != '0);

  // A push into a full TX FIFO is still accepted when the head leaves the same cycle
  assign tx_push    = bus_wr && (reg_sel == 2'd0) && (!tx_full || tx_pop);
  assign tx_ovf_set = bus_wr && (reg_sel == 2'd0) && tx_full && !tx_pop;
  assign rx_pop     = bus_rd && (reg_sel == 2'd0) && rx_not_empty;

  assign status_val = {4'b0000, rx_overrun, tx_overflow, rx_not_empty, !tx_full};

  // TX FIFO storage (contents are don't-care while the count says empty)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= writeData;
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= rxdata;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + FIFO_AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + FIFO_AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + FIFO_AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + FIFO_AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  // FSM state registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  // TX next state: offer the head when the UART is ready, pop as the strobe ends
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:   if (tx_not_empty && txready) tx_next = TX_STROBE;
      TX_STROBE: begin
        tx_pop  = 1'b1;
        tx_next = TX_WAIT;
      end
      TX_WAIT:   if (!txready) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  // RX next state: capture on entry to ACK; a full FIFO withholds the ack
  always_comb begin
    rx_next    = rx_state;
    rx_push    = 1'b0;
    rx_ovr_set = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rxready && !rx_full) begin
          rx_push = 1'b1;
          rx_next = RX_ACK;
        end else if (rxready) begin
          rx_ovr_set = 1'b1;
        end
      end
      RX_ACK:  rx_next = RX_WAIT;
      RX_WAIT: if (!rxready) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  // UART-side registered outputs; txdata is loaded once per strobe and then held
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      txclk  <= 1'b0;
      rxclk  <= 1'b0;
      txdata <= 8'h00;
    end else begin
      txclk <= (tx_next == TX_STROBE);
      rxclk <= (rx_next == RX_ACK);
      if ((tx_state == TX_IDLE) && (tx_next == TX_STROBE)) txdata <= tx_mem[tx_rptr];
    end
  end

  // Sticky error bits: a STATUS read clears them unless set again the same cycle
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      if (tx_ovf_set)     tx_overflow <= 1'b1;
      else if (status_rd) tx_overflow <= 1'b0;
      if (rx_ovr_set)     rx_overrun  <= 1'b1;
      else if (status_rd) rx_overrun  <= 1'b0;
    end
  end

`ifdef UART_BRIDGE_IRQ_EN
  logic rx_irq_en;

  // CTRL register and registered interrupt request
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_irq_en <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (bus_wr && (reg_sel == 2'd2)) rx_irq_en <= writeData[0];
      irq <= rx_irq_en && rx_not_empty;
    end
  end

  assign ctrl_val = {7'b0000000, rx_irq_en};
`else
  assign ctrl_val = 8'h00;
`endif

  // Register read mux; zero unless this is a selected read
  always_comb begin
    readData = 8'h00;
    if (bus_rd) begin
      case (reg_sel)
        2'd0:    if (rx_not_empty) readData = rx_mem[rx_rptr];
        2'd1:    readData = status_val;
        2'd2:    readData = ctrl_val;
        default: readData = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed bench for uart_bus_bridge: a decode/read vector table after reset,
// then hand-written TX, RX, backpressure, same-cycle push/pop and reset sequences.
`timescale 1ns/1ps

module tb_uart_bus_bridge;

  logic       clk = 1'b0;
  logic       nrst;
  logic       readNotWrite;
  logic [7:0] addressBusHigh, addressBusLow, writeData;
  logic [7:0] readData;
  logic       select;
  logic [7:0] txdata;
  logic       txclk, txready;
  logic [7:0] rxdata;
  logic       rxclk, rxready;
`ifdef UART_BRIDGE_IRQ_EN
  logic       irq;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  uart_bus_bridge dut (
    .clk            (clk),
    .nrst           (nrst),
    .readNotWrite   (readNotWrite),
    .addressBusHigh (addressBusHigh),
    .addressBusLow  (addressBusLow),
    .writeData      (writeData),
    .readData       (readData),
    .select         (select),
    .txdata         (txdata),
    .txclk          (txclk),
    .txready        (txready),
    .rxdata         (rxdata),
    .rxclk          (rxclk),
    .rxready        (rxready)
`ifdef UART_BRIDGE_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_sel;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    readNotWrite   = 1'b1;
    addressBusHigh = 8'h00;
    addressBusLow  = 8'h00;
    writeData      = 8'h00;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    readNotWrite = 1'b0;
    {addressBusHigh, addressBusLow} = a;
    writeData = d;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] exp, input string name);
    readNotWrite = 1'b1;
    {addressBusHigh, addressBusLow} = a;
    #1;
    check(name, readData, exp);
    tick();
    bus_idle();
  endtask

  // Tick until txclk is seen, at most 10 cycles
  task automatic wait_txclk(output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (txclk) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rxclk(input int budget, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (rxclk) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // UART taking one byte: raise txready, expect a strobe with the byte, then drop txready
  task automatic tx_take(input logic [7:0] exp, input string name);
    logic seen;
    txready = 1'b1;
    wait_txclk(seen);
    check({name, "_strobe"}, {7'b0, seen}, 8'h01);
    check({name, "_data"}, txdata, exp);
    txready = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   cnt;

    vecs[0]  = '{1'b1, 16'hE000, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{1'b1, 16'hE001, 8'h00, 1'b1, 8'h01};
    vecs[2]  = '{1'b1, 16'hE002, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 16'hE003, 8'h00, 1'b1, 8'h00};
    vecs[4]  = '{1'b1, 16'hE004, 8'h00, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 16'hE0FC, 8'h00, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 16'hE100, 8'h00, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 16'hDF01, 8'h00, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 16'hE003, 8'hFF, 1'b1, 8'h00};
    vecs[9]  = '{1'b0, 16'hE001, 8'hFF, 1'b1, 8'h00};
    vecs[10] = '{1'b1, 16'hE001, 8'h00, 1'b1, 8'h01};
    vecs[11] = '{1'b0, 16'h1234, 8'hAA, 1'b0, 8'h00};

    nrst    = 1'b0;
    txready = 1'b0;
    rxready = 1'b0;
    rxdata  = 8'h00;
    bus_idle();
    #12;
    check("rst_txclk", {7'b0, txclk}, 8'h00);
    check("rst_rxclk", {7'b0, rxclk}, 8'h00);
    check("rst_txdata", txdata, 8'h00);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    // Decode and idle register reads
    for (int i = 0; i < 12; i++) begin
      readNotWrite = vecs[i].rnw;
      {addressBusHigh, addressBusLow} = vecs[i].addr;
      writeData = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_select", i), {7'b0, select}, {7'b0, vecs[i].exp_sel});
      check($sformatf("vec%0d_readData", i), readData, vecs[i].exp_rd);
      tick();
      bus_idle();
    end

    // Single byte transmit with txready held high
    txready = 1'b1;
    bus_write(16'hE000, 8'h41);
    check("tx1_no_early_strobe", {7'b0, txclk}, 8'h00);
    tick();
    check("tx1_strobe", {7'b0, txclk}, 8'h01);
    check("tx1_data", txdata, 8'h41);
    tick();
    check("tx1_strobe_one_cycle", {7'b0, txclk}, 8'h00);
    check("tx1_data_hold", txdata, 8'h41);
    txready = 1'b0;
    tick();
    bus_read(16'hE001, 8'h01, "tx1_status");

    // Five writes into a depth-4 FIFO with the UART stalled
    for (int i = 0; i < 5; i++) bus_write(16'hE000, 8'(8'h10 + i));
    bus_read(16'hE001, 8'h04, "tx_full_overflow_status");
    bus_read(16'hE001, 8'h00, "tx_status_after_clear");
    for (int i = 0; i < 4; i++) tx_take(8'(8'h10 + i), $sformatf("tx_drain%0d", i));
    txready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (txclk) cnt++;
    end
    check("tx_no_fifth_byte", 8'(cnt), 8'h00);
    txready = 1'b0;
    tick();

    // Single byte receive
    rxdata  = 8'h5A;
    rxready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rxclk) begin
        cnt++;
        rxready = 1'b0;
      end
    end
    check("rx1_ack_cycles", 8'(cnt), 8'h01);
    bus_read(16'hE001, 8'h03, "rx1_status_nonempty");
    bus_read(16'hE000, 8'h5A, "rx1_data");
    bus_read(16'hE001, 8'h01, "rx1_status_empty");
    bus_read(16'hE000, 8'h00, "rx_empty_read");

    // RX backpressure: four acks, fifth byte held off until a pop
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      rxdata  = 8'(8'hB0 + i);
      rxready = 1'b1;
      wait_rxclk(6, seen);
      if (seen) begin
        cnt++;
        rxready = 1'b0;
        tick();
        tick();
      end
    end
    check("rx_four_acks", 8'(cnt), 8'h04);
    check("rx_no_fifth_ack", {7'b0, seen}, 8'h00);
    bus_read(16'hE001, 8'h0B, "rx_overrun_status");
    bus_read(16'hE000, 8'hB0, "rx_pop_b0");
    wait_rxclk(6, seen);
    check("rx_fifth_acked_after_pop", {7'b0, seen}, 8'h01);
    rxready = 1'b0;
    tick();
    tick();
    for (int i = 1; i < 5; i++) bus_read(16'hE000, 8'(8'hB0 + i), $sformatf("rx_pop%0d", i));
    bus_read(16'hE001, 8'h09, "rx_overrun_set_wins");
    bus_read(16'hE001, 8'h01, "rx_overrun_cleared");

    // Full TX FIFO: CPU push lands in the strobe cycle that pops the head
    for (int i = 0; i < 4; i++) bus_write(16'hE000, 8'(8'h20 + i));
    txready = 1'b1;
    wait_txclk(seen);
    check("pp_strobe", {7'b0, seen}, 8'h01);
    check("pp_head", txdata, 8'h20);
    bus_write(16'hE000, 8'h24);
    txready = 1'b0;
    tick();
    bus_read(16'hE001, 8'h00, "pp_still_full_no_overflow");

    // Reset asserted in the middle of a strobe
    txready = 1'b1;
    wait_txclk(seen);
    check("rst_mid_strobe_seen", {7'b0, seen}, 8'h01);
    check("rst_mid_strobe_data", txdata, 8'h21);
    #2;
    nrst = 1'b0;
    #1;
    check("rst_mid_txclk", {7'b0, txclk}, 8'h00);
    check("rst_mid_txdata", txdata, 8'h00);
    txready = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    tick();
    bus_read(16'hE001, 8'h01, "rst_fifos_empty");
    txready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (txclk) cnt++;
    end
    check("rst_no_tx_after", 8'(cnt), 8'h00);
    txready = 1'b0;
    tick();

`ifdef UART_BRIDGE_IRQ_EN
    // Interrupt request follows rxNotEmpty one cycle late when enabled
    bus_write(16'hE002, 8'h01);
    bus_read(16'hE002, 8'h01, "irq_ctrl_readback");
    check("irq_idle", {7'b0, irq}, 8'h00);
    rxdata  = 8'hC3;
    rxready = 1'b1;
    wait_rxclk(6, seen);
    check("irq_rx_ack", {7'b0, seen}, 8'h01);
    rxready = 1'b0;
    check("irq_not_yet", {7'b0, irq}, 8'h00);
    tick();
    check("irq_raised", {7'b0, irq}, 8'h01);
    tick();
    bus_read(16'hE000, 8'hC3, "irq_pop");
    check("irq_still_high", {7'b0, irq}, 8'h01);
    tick();
    check("irq_dropped", {7'b0, irq}, 8'h00);
`else
    // CTRL has no storage in this build
    bus_write(16'hE002, 8'hFF);
    bus_read(16'hE002, 8'h00, "ctrl_reads_zero");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
